// File: rtl/tick_timer_pkg.sv
// Shared types and digit moduli for the tick-driven MM:SS stopwatch.
package tick_timer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} timer_state_t;

  typedef logic [3:0] bcd_t;

  localparam int SEC_TENS_MOD = 6;
  localparam int DIGIT_MOD    = 10;

endpackage

// File: rtl/bcd_digit.sv
// One mod-MOD BCD digit; carry is combinational so a chain of digits
// advances in a single cycle.
module bcd_digit
  import tick_timer_pkg::*;
#(
  parameter int MOD = 10
) (
  input  logic clk,
  input  logic rs_n,
  input  logic inc,
  input  logic clr,
  output bcd_t q,
  output logic carry
);

  localparam bcd_t LAST = bcd_t'(MOD - 1);

  assign carry = inc && (q == LAST);

  always_ff @(posedge clk or negedge rs_n) begin
    if (!rs_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= (q == LAST) ? '0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/tick_bcd_timer.sv
// Stopwatch: prescales divider ticks into seconds and accumulates MM:SS in BCD
// with start/stop/clear control and a lap freeze of the displayed value.
module tick_bcd_timer
  import tick_timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1
) (
  input  logic clk,
  input  logic rs_n,
  input  logic tick,
  input  logic start,
  input  logic stop,
  input  logic clear,
  input  logic lap,
  output bcd_t sec_ones,
  output bcd_t sec_tens,
  output bcd_t min_ones,
  output bcd_t min_tens,
  output logic running,
  output logic frozen,
  output logic wrap
);

  localparam logic [7:0] PCNT_LAST = 8'(TICKS_PER_SEC - 1);

  timer_state_t     state;
  logic [7:0]       pcnt;
  logic             run_tick;
  logic [4:0]       inc_chain;
  bcd_t [3:0]       live;
  bcd_t [3:0]       snap;

  // clear gates the increment so a coincident tick is discarded
  assign run_tick     = (state == RUN) && tick && !clear;
  assign inc_chain[0] = run_tick && (pcnt == PCNT_LAST);

  for (genvar i = 0; i < 4; i++) begin : g_digit
    bcd_digit #(.MOD((i == 1) ? SEC_TENS_MOD : DIGIT_MOD)) u_digit (
      .clk   (clk),
      .rs_n  (rs_n),
      .inc   (inc_chain[i]),
      .clr   (clear),
      .q     (live[i]),
      .carry (inc_chain[i+1])
    );
  end

  always_ff @(posedge clk or negedge rs_n) begin
    if (!rs_n) begin
      state   <= IDLE;
      running <= 1'b0;
    end else if (clear) begin
      state   <= IDLE;
      running <= 1'b0;
    end else if (stop) begin
      if (state == RUN) begin
        state   <= PAUSE;
        running <= 1'b0;
      end
    end else if (start && state != RUN) begin
      state   <= RUN;
      running <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rs_n) begin
    if (!rs_n) begin
      pcnt <= '0;
    end else if (clear) begin
      pcnt <= '0;
    end else if (run_tick) begin
      pcnt <= (pcnt == PCNT_LAST) ? 8'd0 : pcnt + 8'd1;
    end
  end

  // snapshot takes the pre-edge live count, so a coincident increment is excluded
  always_ff @(posedge clk or negedge rs_n) begin
    if (!rs_n) begin
      frozen <= 1'b0;
      snap   <= '0;
    end else if (clear) begin
      frozen <= 1'b0;
    end else if (lap && state == RUN) begin
      frozen <= !frozen;
      if (!frozen) snap <= live;
    end
  end

  always_ff @(posedge clk or negedge rs_n) begin
    if (!rs_n) wrap <= 1'b0;
    else       wrap <= inc_chain[4];
  end

  assign sec_ones = frozen ? snap[0] : live[0];
  assign sec_tens = frozen ? snap[1] : live[1];
  assign min_ones = frozen ? snap[2] : live[2];
  assign min_tens = frozen ? snap[3] : live[3];

endmodule

// File: tb/tb_tick_bcd_timer.sv
// Scoreboarded bench for tick_bcd_timer: two instances (1 and 4 ticks/sec)
// share stimulus and are compared against an elapsed-seconds model.
module tb_tick_bcd_timer;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;

  typedef struct packed {
    logic [18:0] a;
    logic [18:0] b;
  } exp_t;

  logic clk = 1'b0;
  logic rs_n, tick, start, stop, clear, lap;
  logic [3:0] so_a, st_a, mo_a, mt_a, so_b, st_b, mo_b, mt_b;
  logic run_a, fr_a, wr_a, run_b, fr_b, wr_b;

  int total = 0;
  int bad   = 0;
  exp_t q[$];

  int tps[2];
  int st[2];
  int secs[2];
  int pc[2];
  int snapv[2];
  bit fr[2];
  bit wr[2];

  always #5 clk = ~clk;

  tick_bcd_timer #(.TICKS_PER_SEC(1)) dut_a (
    .clk(clk), .rs_n(rs_n), .tick(tick), .start(start), .stop(stop),
    .clear(clear), .lap(lap), .sec_ones(so_a), .sec_tens(st_a),
    .min_ones(mo_a), .min_tens(mt_a), .running(run_a), .frozen(fr_a), .wrap(wr_a)
  );

  tick_bcd_timer #(.TICKS_PER_SEC(4)) dut_b (
    .clk(clk), .rs_n(rs_n), .tick(tick), .start(start), .stop(stop),
    .clear(clear), .lap(lap), .sec_ones(so_b), .sec_tens(st_b),
    .min_ones(mo_b), .min_tens(mt_b), .running(run_b), .frozen(fr_b), .wrap(wr_b)
  );

  wire [18:0] got_a = {mt_a, mo_a, st_a, so_a, run_a, fr_a, wr_a};
  wire [18:0] got_b = {mt_b, mo_b, st_b, so_b, run_b, fr_b, wr_b};
  wire [15:0] dig_a = {mt_a, mo_a, st_a, so_a};

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      st[i] = S_IDLE; secs[i] = 0; pc[i] = 0; snapv[i] = 0; fr[i] = 0; wr[i] = 0;
    end
  endtask

  task automatic model_step(input bit t, input bit s, input bit p, input bit c, input bit l);
    for (int i = 0; i < 2; i++) begin
      if (c) begin
        secs[i] = 0; pc[i] = 0; fr[i] = 0; wr[i] = 0; st[i] = S_IDLE;
      end else begin
        wr[i] = 0;
        if (st[i] == S_RUN) begin
          if (l) begin
            if (!fr[i]) snapv[i] = secs[i];
            fr[i] = !fr[i];
          end
          if (t) begin
            pc[i]++;
            if (pc[i] == tps[i]) begin
              pc[i]   = 0;
              secs[i] = (secs[i] + 1) % 6000;
              wr[i]   = (secs[i] == 0);
            end
          end
        end
        if (p) begin
          if (st[i] == S_RUN) st[i] = S_PAUSE;
        end else if (s && st[i] != S_RUN) begin
          st[i] = S_RUN;
        end
      end
    end
  endtask

  function automatic logic [18:0] disp(input int i);
    int d;
    d = fr[i] ? snapv[i] : secs[i];
    return {4'(d / 600), 4'((d / 60) % 10), 4'((d % 60) / 10), 4'(d % 10),
            st[i] == S_RUN, fr[i], wr[i]};
  endfunction

  task automatic cyc(input bit t, input bit s, input bit p, input bit c, input bit l);
    exp_t e;
    @(negedge clk);
    rs_n = 1'b1; tick = t; start = s; stop = p; clear = c; lap = l;
    model_step(t, s, p, c, l);
    e.a = disp(0);
    e.b = disp(1);
    q.push_back(e);
  endtask

  task automatic ticks(input int n);
    repeat (n) cyc(1, 0, 0, 0, 0);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // monitor: every cycle the DUTs present a new registered result
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        total++;
        if (got_a !== e.a) begin
          bad++;
          $display("FAIL scb_a t=%0t got=%h exp=%h", $time, got_a, e.a);
        end
        total++;
        if (got_b !== e.b) begin
          bad++;
          $display("FAIL scb_b t=%0t got=%h exp=%h", $time, got_b, e.b);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    tps[0] = 1;
    tps[1] = 4;
    model_reset();
    rs_n = 1'b0; tick = 0; start = 0; stop = 0; clear = 0; lap = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_a", got_a, 19'h0);
    chk("reset_b", got_b, 19'h0);

    ticks(20);
    settle();
    chk("idle_digits", dig_a, 16'h0000);
    chk("idle_running", run_a, 1'b0);

    cyc(1, 1, 0, 0, 0);
    ticks(10);
    settle();
    chk("prescale_b_sec_ones", so_b, 4'd2);
    ticks(49);
    settle();
    chk("carry_0059", dig_a, 16'h0059);
    ticks(1);
    settle();
    chk("carry_0100", dig_a, 16'h0100);

    cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0);
    ticks(5999);
    settle();
    chk("wrap_9959", dig_a, 16'h9959);
    ticks(1);
    settle();
    chk("wrap_0000", dig_a, 16'h0000);
    chk("wrap_pulse", wr_a, 1'b1);
    chk("wrap_running", run_a, 1'b1);
    cyc(0, 0, 0, 0, 0);
    settle();
    chk("wrap_single", wr_a, 1'b0);

    cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0);
    ticks(5);
    cyc(1, 0, 1, 0, 0);
    settle();
    chk("stop_tick_counted", dig_a, 16'h0006);
    chk("stop_running", run_a, 1'b0);
    ticks(10);
    settle();
    chk("pause_hold", dig_a, 16'h0006);
    cyc(0, 1, 0, 0, 0);
    ticks(3);
    settle();
    chk("resume", dig_a, 16'h0009);
    cyc(1, 0, 0, 1, 0);
    settle();
    chk("clear_tick", dig_a, 16'h0000);
    chk("clear_running", run_a, 1'b0);

    cyc(0, 1, 0, 0, 0);
    ticks(12);
    cyc(0, 0, 0, 0, 1);
    settle();
    chk("lap_frozen", fr_a, 1'b1);
    ticks(5);
    settle();
    chk("lap_hold", dig_a, 16'h0012);
    cyc(0, 0, 0, 0, 1);
    settle();
    chk("lap_release", dig_a, 16'h0017);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);

    cyc(0, 1, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      cyc(1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0,
          $urandom_range(0, 29) == 0, $urandom_range(0, 199) == 0,
          $urandom_range(0, 24) == 0);
    end

    cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0);
    ticks(7);
    @(negedge clk);
    rs_n = 1'b0; tick = 0; start = 0; stop = 0; clear = 0; lap = 0;
    #1;
    chk("async_reset_a", got_a, 19'h0);
    chk("async_reset_b", got_b, 19'h0);
    model_reset();
    q.push_back('0);
    ticks(4);

    repeat (4) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tick_bcd_timer.md
# tick_bcd_timer

Stopwatch stage directly downstream of the `countern` tick divider. It consumes the divider's one-cycle `OUT` pulse as `tick`. It prescales the pulses into seconds and accumulates elapsed time as a four-digit BCD MM:SS value, under start/stop/clear/lap control. Outputs are registered and feed the seven-segment display driver.

## Interface
- `TICKS_PER_SEC`, default 1: number of `tick` pulses per second; legal range 1..255.
- `clk` in 1: system clock; all logic rises on posedge.
- `rs_n` in 1: asynchronous reset, active-low. Assertion is asynchronous; release is synchronised externally.
- `tick` in 1: one-cycle pulse from `countern.OUT`.
- `start` in 1: one-cycle command to begin or resume counting.
- `stop` in 1: one-cycle command to pause.
- `clear` in 1: one-cycle command to zero the timer and return to idle.
- `lap` in 1: one-cycle command to toggle display freeze.
- `sec_ones` out 4: displayed seconds, ones digit, BCD 0..9.
- `sec_tens` out 4: displayed seconds, tens digit, BCD 0..5.
- `min_ones` out 4: displayed minutes, ones digit, BCD 0..9.
- `min_tens` out 4: displayed minutes, tens digit, BCD 0..9.
- `running` out 1: high while the FSM is in RUN.
- `frozen` out 1: high while the display is frozen by `lap`.
- `wrap` out 1: one-cycle pulse when the count rolls from 99:59 to 00:00.

## Operation
- The FSM has three states: IDLE, RUN and PAUSE. Reset state is IDLE.
- Command priority within one cycle is `clear` > `stop` > `start`.
- Transitions:
  - IDLE + `start` → RUN.
  - RUN + `stop` → PAUSE.
  - PAUSE + `start` → RUN.
  - Any state + `clear` → IDLE.
  - `start` in RUN is ignored. `stop` in IDLE or PAUSE is ignored.
- Prescaler:
  - An 8-bit counter `pcnt` increments on `tick` only while the *current* state is RUN.
  - When `pcnt == TICKS_PER_SEC-1` and `tick` is high, `pcnt` returns to 0 and the seconds value advances by 1.
  - With `TICKS_PER_SEC` = 1, every tick advances the seconds.
- BCD chain:
  - Digit moduli are 10 (sec_ones), 6 (sec_tens), 10 (min_ones) and 10 (min_tens).
  - Each digit carries into the next when it wraps to 0.
  - A carry out of `min_tens` raises `wrap` for one cycle. Counting continues from 00:00.
- Lap:
  - `lap` while in RUN toggles `frozen`. `lap` in IDLE or PAUSE is ignored.
  - While `frozen` is high, the outputs hold the values captured in the cycle `lap` was sampled. The internal count keeps advancing.
  - Unfreezing shows the live count again on the next cycle.
- Clear:
  - Zeroes all four digits and `pcnt`.
  - Drops `frozen` and `running`.
  - Forces the FSM to IDLE.
- Held `pcnt` and digits are retained across PAUSE.

## Timing
- Reset values: all digits 0, `running` = 0, `frozen` = 0, `wrap` = 0, `pcnt` = 0, state IDLE.
- Command latency: a command sampled at edge N changes the state and `running` after edge N.
- A `tick` coincident with `start` from IDLE is not counted, because the state is still IDLE in that cycle.
- A `tick` coincident with `stop` in RUN is counted.
- A `tick` coincident with `clear` is discarded; clear wins and the digits read 0 after the edge.
- Count latency: a qualifying tick at edge N shows on the digit outputs after edge N (one cycle, registered).
- `wrap` asserts in the same cycle the digits first read 00:00 after the roll.
- `lap` coincident with a second increment: the frozen value is the pre-increment count.
- `rs_n` asserted mid-count forces reset values immediately, regardless of clock.

## Structure
- Shared package `tick_timer_pkg` contains:
  - `typedef enum logic [1:0] {IDLE, RUN, PAUSE} timer_state_t`
  - `typedef logic [3:0] bcd_t`
  - constants `SEC_TENS_MOD = 6` and `DIGIT_MOD = 10`
- Sub-module `bcd_digit` implements one mod-N BCD digit:
  - parameter `MOD`
  - inputs `inc` and `clr`
  - outputs `q` and `carry`
  - It is instantiated four times, chained carry-to-inc.
- Top level contains the FSM, the prescaler, the freeze register and the output muxing.

## Test plan
- Reset and idle: reset, then 20 ticks with no `start` → all digits 0, `running` = 0.
- Prescale: `TICKS_PER_SEC` = 4, `start`, then 10 ticks → `sec_ones` = 2, `pcnt` = 2.
- Carry: `TICKS_PER_SEC` = 1, run 59 ticks → 00:59; one more tick → `min_ones` = 1 and both seconds digits 0.
- Wrap: preload by running 5999 ticks → 99:59; the next tick shows 00:00 with a single-cycle `wrap` pulse; `running` stays 1.
- Pause and simultaneous commands:
  - `stop` coincident with a tick at 00:05 → 00:06 then holds during 10 ticks.
  - `start` resumes.
  - `clear` coincident with a tick → 00:00 and state IDLE.
- Lap and reset: at 00:12, `lap` → display holds 00:12 while 5 ticks elapse; second `lap` → 00:17. Assert `rs_n` low mid-run → immediate zero outputs.
